// File: rtl/wd_pkg.sv
// Shared definitions for the watchdog APB completer: register map, CTRL bits,
// reset/unlock constants and the bus operation type.
package wd_pkg;

  localparam logic [7:0] WD_LOAD   = 8'h00;
  localparam logic [7:0] WD_VALUE  = 8'h04;
  localparam logic [7:0] WD_CTRL   = 8'h08;
  localparam logic [7:0] WD_INTCLR = 8'h0C;
  localparam logic [7:0] WD_RIS    = 8'h10;
  localparam logic [7:0] WD_MIS    = 8'h14;
  localparam logic [7:0] WD_LOCK   = 8'hC0;

  localparam int WD_CTRL_INTEN = 0;
  localparam int WD_CTRL_RESEN = 1;

  localparam logic [31:0] WD_UNLOCK_KEY = 32'h1ACC_E551;
  localparam logic [31:0] WD_LOAD_RST   = 32'hFFFF_FFFF;

  typedef enum logic {
    WD_OP_READ  = 1'b0,
    WD_OP_WRITE = 1'b1
  } wd_op_e;

endpackage

// File: rtl/wd_counter.sv
// Watchdog timebase: prescaler plus down-counter. A reload always wins over
// the tick; expiry is flagged only when the zero value is actually consumed.
module wd_counter #(
  parameter int                DATA_W   = 32,
  parameter int                PRESCALE = 1,
  parameter logic [DATA_W-1:0] LOAD_RST = '1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              reload_i,
  input  logic [DATA_W-1:0] load_val_i,
  output logic [DATA_W-1:0] value_o,
  output logic              expire_o
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]   ps_q, ps_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              tick;

  always_comb begin
    tick     = en_i && (ps_q == PS_W'(PRESCALE - 1));
    ps_d     = ps_q;
    value_d  = value_q;
    expire_o = 1'b0;
    if (en_i) begin
      ps_d = tick ? '0 : ps_q + 1'b1;
    end
    if (reload_i) begin
      value_d = load_val_i;
    end else if (tick) begin
      if (value_q == '0) begin
        value_d  = load_val_i;
        expire_o = 1'b1;
      end else begin
        value_d = value_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ps_q    <= '0;
      value_q <= LOAD_RST;
    end else begin
      ps_q    <= ps_d;
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/wd_apb_slave.sv
// Watchdog APB completer: register file, address decode, lock and the
// interrupt/timeout flags around the wd_counter timebase.
module wd_apb_slave
  import wd_pkg::*;
#(
  parameter int                ADDR_W     = 8,
  parameter int                DATA_W     = 32,
  parameter int                PRESCALE   = 1,
  parameter logic [DATA_W-1:0] LOAD_RST   = WD_LOAD_RST,
  parameter logic [DATA_W-1:0] UNLOCK_KEY = WD_UNLOCK_KEY
) (
  input  logic              pclk_i,
  input  logic              preset_n_i,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [DATA_W-1:0] pwdata_i,
  output logic [DATA_W-1:0] prdata_o,
  output logic              timeout_o,
  output logic              intr_o
);

  logic [DATA_W-1:0] load_q, load_d, prdata_q, prdata_d, rdata;
  logic [DATA_W-1:0] cnt_value, cnt_load_val;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              ris_q, ris_d, timeout_q, timeout_d, locked_q, locked_d;
  logic              wr, rd, wr_ok, wr_load, wr_ctrl, wr_intclr, wr_lock;
  logic              cnt_reload, expire;

  always_comb begin
    wr           = psel_i & penable_i & pwrite_i;
    rd           = psel_i & penable_i & ~pwrite_i;
    wr_ok        = wr & ~locked_q;
    wr_load      = wr_ok & (paddr_i == ADDR_W'(WD_LOAD));
    wr_ctrl      = wr_ok & (paddr_i == ADDR_W'(WD_CTRL));
    wr_intclr    = wr_ok & (paddr_i == ADDR_W'(WD_INTCLR));
    wr_lock      = wr & (paddr_i == ADDR_W'(WD_LOCK));
    cnt_reload   = wr_load | wr_intclr;
    cnt_load_val = wr_load ? pwdata_i : load_q;
  end

  wd_counter #(
    .DATA_W  (DATA_W),
    .PRESCALE(PRESCALE),
    .LOAD_RST(LOAD_RST)
  ) u_counter (
    .clk_i     (pclk_i),
    .rst_n_i   (preset_n_i),
    .en_i      (ctrl_q[WD_CTRL_INTEN]),
    .reload_i  (cnt_reload),
    .load_val_i(cnt_load_val),
    .value_o   (cnt_value),
    .expire_o  (expire)
  );

  always_comb begin
    rdata = '0;
    case (paddr_i)
      ADDR_W'(WD_LOAD):  rdata = load_q;
      ADDR_W'(WD_VALUE): rdata = cnt_value;
      ADDR_W'(WD_CTRL):  rdata = {{(DATA_W-2){1'b0}}, ctrl_q};
      ADDR_W'(WD_RIS):   rdata = {{(DATA_W-1){1'b0}}, ris_q};
      ADDR_W'(WD_MIS):   rdata = {{(DATA_W-1){1'b0}}, ris_q & ctrl_q[WD_CTRL_INTEN]};
      ADDR_W'(WD_LOCK):  rdata = {{(DATA_W-1){1'b0}}, locked_q};
      default:           rdata = '0;
    endcase
  end

  // INTCLR outranks expiry; expire is already suppressed by any reload.
  always_comb begin
    load_d    = wr_load ? pwdata_i : load_q;
    ctrl_d    = wr_ctrl ? pwdata_i[1:0] : ctrl_q;
    locked_d  = wr_lock ? (pwdata_i != UNLOCK_KEY) : locked_q;
    prdata_d  = rd ? rdata : prdata_q;
    ris_d     = ris_q;
    timeout_d = timeout_q;
    if (wr_intclr) begin
      ris_d     = 1'b0;
      timeout_d = 1'b0;
    end else if (expire) begin
      ris_d = 1'b1;
      if (ris_q && ctrl_q[WD_CTRL_RESEN]) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk_i or negedge preset_n_i) begin
    if (!preset_n_i) begin
      load_q    <= LOAD_RST;
      ctrl_q    <= '0;
      locked_q  <= 1'b0;
      ris_q     <= 1'b0;
      timeout_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      load_q    <= load_d;
      ctrl_q    <= ctrl_d;
      locked_q  <= locked_d;
      ris_q     <= ris_d;
      timeout_q <= timeout_d;
      prdata_q  <= prdata_d;
    end
  end

  assign prdata_o  = prdata_q;
  assign timeout_o = timeout_q;
  assign intr_o    = ris_q & ctrl_q[WD_CTRL_INTEN];

endmodule

// File: tb/tb_wd_apb_slave.sv
// Bench for wd_apb_slave: two instances (PRESCALE 1 and 4) on a shared APB bus,
// read expectations queued at issue and compared when prdata is returned.
module tb_wd_apb_slave;
  import wd_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, psel_a, psel_b, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata_a, prdata_b;
  logic        timeout_a, intr_a, timeout_b, intr_b;

  int          cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  wd_apb_slave #(.PRESCALE(1)) u_dut_a (
    .pclk_i(clk), .preset_n_i(rst_n), .psel_i(psel_a), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata_a), .timeout_o(timeout_a), .intr_o(intr_a)
  );

  wd_apb_slave #(.PRESCALE(4)) u_dut_b (
    .pclk_i(clk), .preset_n_i(rst_n), .psel_i(psel_b), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata_b), .timeout_o(timeout_b), .intr_o(intr_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic apb(input int dut, input wd_op_e op, input logic [7:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp, input string tag);
    logic [31:0] act;
    if (op == WD_OP_READ) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    psel_a  = (dut == 0);
    psel_b  = (dut == 1);
    penable = 1'b0;
    pwrite  = (op == WD_OP_WRITE);
    paddr   = addr;
    pwdata  = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    if (op == WD_OP_READ) begin
      act = (dut == 0) ? prdata_a : prdata_b;
      chk(tag_q.pop_front(), act, exp_q.pop_front());
    end
  endtask

  task automatic wr(input int dut, input logic [7:0] addr, input logic [31:0] data);
    apb(dut, WD_OP_WRITE, addr, data, 32'h0, "");
  endtask

  task automatic rd(input int dut, input logic [7:0] addr, input logic [31:0] exp,
                    input string tag);
    apb(dut, WD_OP_READ, addr, 32'h0, exp, tag);
  endtask

  // Returns the cycle number at which the flag is first seen high, -1 on timeout.
  task automatic wait_hi(input int dut, input bit tmo, input int limit, output int at);
    logic s;
    at = -1;
    for (int n = 0; n < limit; n++) begin
      s = (dut == 0) ? (tmo ? timeout_a : intr_a) : (tmo ? timeout_b : intr_b);
      if (s) begin
        at = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int t0, t1, t2;
    rst_n = 1'b0; psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
    pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_intr", {31'b0, intr_a}, 32'h0);
    chk("rst_tmo", {31'b0, timeout_a}, 32'h0);
    chk("rst_prdata", prdata_a, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rd(0, WD_LOAD,  32'hFFFF_FFFF, "rst_load");
    rd(0, WD_CTRL,  32'h0,         "rst_ctrl");
    rd(0, WD_RIS,   32'h0,         "rst_ris");
    rd(0, WD_LOCK,  32'h0,         "rst_lock");
    rd(0, WD_VALUE, 32'hFFFF_FFFF, "rst_value");

    // first expiry -> intr, second with RESEN -> timeout
    wr(0, WD_LOAD, 32'd10);
    wr(0, WD_CTRL, 32'd1);
    t0 = cyc;
    wait_hi(0, 1'b0, 40, t1);
    chk("intr_latency", t1 - t0, 32'd11);
    rd(0, WD_VALUE, 32'd9, "value_after_reload");
    wr(0, WD_CTRL, 32'd3);
    wait_hi(0, 1'b1, 40, t2);
    chk("tmo_latency", t2 - t1, 32'd11);
    repeat (15) @(posedge clk);
    #1;
    chk("tmo_sticky", {31'b0, timeout_a}, 32'h1);
    chk("intr_held", {31'b0, intr_a}, 32'h1);
    rd(0, WD_RIS, 32'h1, "ris_set");
    rd(0, WD_MIS, 32'h1, "mis_set");

    // INTCLR lands on the same edge as expiry
    wr(0, WD_LOAD, 32'd3);
    repeat (2) @(posedge clk);
    #1;
    wr(0, WD_INTCLR, 32'h0);
    chk("clr_intr", {31'b0, intr_a}, 32'h0);
    chk("clr_tmo", {31'b0, timeout_a}, 32'h0);
    rd(0, WD_VALUE, 32'd2, "clr_value");

    // lock
    wr(0, WD_LOCK, 32'h0);
    rd(0, WD_LOCK, 32'h1, "locked");
    wr(0, WD_LOAD, 32'd5);
    rd(0, WD_LOAD, 32'd3, "locked_load");
    wr(0, WD_LOCK, WD_UNLOCK_KEY);
    rd(0, WD_LOCK, 32'h0, "unlocked");
    wr(0, WD_LOAD, 32'd5);
    rd(0, WD_LOAD, 32'd5, "unlocked_load");

    rd(0, 8'h20,     32'h0, "unmapped_read");
    rd(0, WD_INTCLR, 32'h0, "wo_read");

    // prescaled instance, then freeze via INTEN=0
    wr(1, WD_LOAD, 32'd2);
    wr(1, WD_CTRL, 32'd1);
    t0 = cyc;
    wait_hi(1, 1'b0, 40, t1);
    chk("ps_intr_latency", t1 - t0, 32'd12);
    wr(1, WD_CTRL, 32'd0);
    chk("ps_intr_masked", {31'b0, intr_b}, 32'h0);
    rd(1, WD_VALUE, 32'd2, "freeze_value0");
    repeat (20) @(posedge clk);
    #1;
    rd(1, WD_VALUE, 32'd2, "freeze_value1");
    rd(1, WD_RIS,   32'h1, "ps_ris");
    rd(1, WD_MIS,   32'h0, "ps_mis");

    // async reset while counting with flags raised
    wait_hi(0, 1'b1, 60, t2);
    chk("pre_rst_tmo", {31'b0, timeout_a}, 32'h1);
    rd(0, WD_LOAD, 32'd5, "pre_rst_load");
    chk("pre_rst_intr", {31'b0, intr_a}, 32'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_intr", {31'b0, intr_a}, 32'h0);
    chk("arst_tmo", {31'b0, timeout_a}, 32'h0);
    chk("arst_prdata_a", prdata_a, 32'h0);
    chk("arst_prdata_b", prdata_b, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd(0, WD_LOAD, 32'hFFFF_FFFF, "post_rst_load");
    rd(0, WD_CTRL, 32'h0,         "post_rst_ctrl");
    rd(1, WD_RIS,  32'h0,         "post_rst_ris_b");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
